// File: rtl/instr_encoder_loader.sv
// Encodes simple RV32I instruction requests into machine words and streams them
// into an instruction memory, one word per three cycles, with sticky illegal-kind flag.
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_in_kind,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [31:0]       i_in_imm,
  input  logic              i_clear,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err_illegal
);

  localparam logic [3:0] K_ADD   = 4'd0;
  localparam logic [3:0] K_SUB   = 4'd1;
  localparam logic [3:0] K_LW    = 4'd2;
  localparam logic [3:0] K_SW    = 4'd3;
  localparam logic [3:0] K_BEQ   = 4'd4;
  localparam logic [3:0] K_ADDI  = 4'd5;
  localparam logic [3:0] K_JAL   = 4'd6;
  localparam logic [3:0] K_JALR  = 4'd7;
  localparam logic [3:0] K_LUI   = 4'd8;
  localparam logic [3:0] K_AUIPC = 4'd9;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [2:0] F3_ZERO = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Unused register fields are forced to zero; out-of-range immediate bits drop out.
  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    case (kind)
      K_ADD:   word = {F7_ADD, rs2, rs1, F3_ZERO, rd, OP_R};
      K_SUB:   word = {F7_SUB, rs2, rs1, F3_ZERO, rd, OP_R};
      K_LW:    word = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
      K_SW:    word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
      K_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, F3_ZERO, imm[4:1], imm[11], OP_BR};
      K_ADDI:  word = {imm[11:0], rs1, F3_ZERO, rd, OP_IMM};
      K_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      K_JALR:  word = {imm[11:0], rs1, F3_ZERO, rd, OP_JALR};
      K_LUI:   word = {imm[31:12], rd, OP_LUI};
      K_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_kind;
  logic [4:0]          r_rd;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [31:0]         r_imm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_err;
  logic                w_ready;
  logic                w_accept;
  logic                w_legal;
  logic [ADDR_W:0]     w_count_inc;

  // Ready is held low during reset so nothing is accepted while the block is cleared.
  assign w_ready     = i_rst_n & (r_state == ST_IDLE) & ~r_full & ~i_clear;
  assign w_accept    = i_in_valid & w_ready;
  assign w_legal     = (r_kind <= K_AUIPC);
  assign w_count_inc = r_count + CNT_ONE;

  assign o_in_ready    = w_ready;
  assign o_imem_we     = r_we;
  assign o_imem_addr   = r_addr;
  assign o_imem_wdata  = r_wdata;
  assign o_count       = r_count;
  assign o_full        = r_full;
  assign o_err_illegal = r_err;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; clear wins over any accept or pending write.
  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_next_state = ST_ENC;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_ENC: begin
          if (w_legal) begin
            w_next_state = ST_WRITE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_WRITE: w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // Request field capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kind <= 4'd0;
      r_rd   <= 5'd0;
      r_rs1  <= 5'd0;
      r_rs2  <= 5'd0;
      r_imm  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_kind <= i_in_kind;
      r_rd   <= i_in_rd;
      r_rs1  <= i_in_rs1;
      r_rs2  <= i_in_rs2;
      r_imm  <= i_in_imm;
    end
  end

  // Write strobe, address/count bookkeeping and sticky illegal flag.
  // Write data is left alone on clear so it keeps the last word written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_clear) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_ENC: begin
          if (w_legal) begin
            r_wdata <= encode(r_kind, r_rd, r_rs1, r_rs2, r_imm);
            r_we    <= 1'b1;
          end else begin
            r_err   <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_count <= w_count_inc;
          r_full  <= (w_count_inc == DEPTH_CNT);
          // Saturate on the last word so the address never wraps to zero.
          if (r_addr != LAST_ADDR) begin
            r_addr <= r_addr + ADDR_ONE;
          end
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

endmodule
